// File: rtl/fir_coeff_sequencer_pkg.sv
// Shared definitions for the FIR coefficient sequencer: FSM encoding and tap slicing.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package fir_coeff_sequencer_pkg;

  // Encodings are fixed so that state values stay meaningful in waveforms and debug logs.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_SETTLE  = 2'd2
  } state_e;

  // LSB position of tap 'tap' on a packed coefficient bus of 'width'-bit taps.
  function automatic int tap_lsb(input int tap, input int width);
    return tap * width;
  endfunction

endpackage

// File: rtl/fir_coeff_sequencer_bank.sv
// Coefficient register bank: N+1 signed taps with load-all, single-tap write and identity reset.
// Latency: a load or write is visible on coeffs the cycle after the capturing edge.
// Backpressure: none; the bank always accepts, and the caller decides when to enable.
module fir_coeff_bank
  import fir_coeff_sequencer_pkg::*;
#(
  parameter int N           = 4,
  parameter int COEFF_WIDTH = 16,
  parameter int ADDR_WIDTH  = 3,
  parameter int Q           = 14
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           load_en,
  input  logic [COEFF_WIDTH*(N+1)-1:0]   load_dat,
  input  logic                           wr_en,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [COEFF_WIDTH-1:0]         wr_dat,
  output logic [COEFF_WIDTH*(N+1)-1:0]   coeffs
);

  localparam logic [COEFF_WIDTH-1:0] IDENT = COEFF_WIDTH'(1) << Q;

  logic [COEFF_WIDTH-1:0] tap_q [0:N];
  logic [COEFF_WIDTH-1:0] tap_d [0:N];

  // Next tap values: a full load wins over a single-tap write.
  always_comb begin
    for (int t = 0; t <= N; t++) begin
      tap_d[t] = tap_q[t];
      if (load_en) begin
        tap_d[t] = load_dat[tap_lsb(t, COEFF_WIDTH) +: COEFF_WIDTH];
      end else if (wr_en && (wr_addr == ADDR_WIDTH'(t))) begin
        tap_d[t] = wr_dat;
      end
    end
  end

  // Tap storage; reset restores the pass-through (identity) filter.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t <= N; t++) begin
        tap_q[t] <= '0;
      end
      tap_q[0] <= IDENT;
    end else begin
      for (int t = 0; t <= N; t++) begin
        tap_q[t] <= tap_d[t];
      end
    end
  end

  for (genvar g = 0; g <= N; g++) begin : g_pack
    assign coeffs[tap_lsb(g, COEFF_WIDTH) +: COEFF_WIDTH] = tap_q[g];
  end

endmodule

// File: rtl/fir_coeff_sequencer.sv
// Coefficient owner for the FIR: host writes a shadow bank, commit swaps it in on a sample strobe.
// Latency: swap lands on the first sample_en after the commit cycle; settled after N+1 more strobes.
// Backpressure: wr_ready drops while a swap is pending, so the shadow is frozen until it lands.
module fir_coeff_sequencer
  import fir_coeff_sequencer_pkg::*;
#(
  parameter int N           = 4,
  parameter int COEFF_WIDTH = 16,
  parameter int ADDR_WIDTH  = 3,
  parameter int Q           = 14
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [COEFF_WIDTH-1:0]         wr_data,
  input  logic                           commit,
  input  logic                           sample_en,
  output logic [COEFF_WIDTH*(N+1)-1:0]   packed_coeffs,
  output logic                           busy,
  output logic                           settled,
  output logic                           addr_err
);

  localparam logic [ADDR_WIDTH-1:0] LAST_TAP    = ADDR_WIDTH'(N);
  localparam logic [ADDR_WIDTH:0]   SETTLE_LAST = (ADDR_WIDTH + 1)'(N);

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH:0]    cnt_q, cnt_d;
  logic                   wr_ready_q, wr_ready_d;
  logic                   busy_q, busy_d;
  logic                   settled_q, settled_d;
  logic                   addr_err_q, addr_err_d;

  logic                   wr_fire;
  logic                   in_range;
  logic                   swap;
  logic [COEFF_WIDTH*(N+1)-1:0] shadow_coeffs;

  assign wr_fire  = wr_valid & wr_ready_q;
  assign in_range = (wr_addr <= LAST_TAP);
  // The swap coincides with the delay-line shift, so the filter switches sets between samples.
  assign swap     = (state_q == ST_PENDING) & sample_en;

  // Next-state, settle count and decoded status; commit in SETTLE wins over a coincident strobe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (commit) state_d = ST_PENDING;
      end
      ST_PENDING: begin
        if (sample_en) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end
      end
      ST_SETTLE: begin
        if (commit) begin
          state_d = ST_PENDING;
          cnt_d   = '0;
        end else if (sample_en) begin
          if (cnt_q == SETTLE_LAST) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    wr_ready_d = (state_d != ST_PENDING);
    busy_d     = (state_d == ST_PENDING);
    settled_d  = (state_d == ST_IDLE);
    addr_err_d = wr_fire & ~in_range;
  end

  // Control state and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      wr_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      settled_q  <= 1'b1;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_ready_q <= wr_ready_d;
      busy_q     <= busy_d;
      settled_q  <= settled_d;
      addr_err_q <= addr_err_d;
    end
  end

  fir_coeff_bank #(
    .N(N), .COEFF_WIDTH(COEFF_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .Q(Q)
  ) u_shadow (
    .clk      (clk),
    .rst      (rst),
    .load_en  (1'b0),
    .load_dat ('0),
    .wr_en    (wr_fire & in_range),
    .wr_addr  (wr_addr),
    .wr_dat   (wr_data),
    .coeffs   (shadow_coeffs)
  );

  fir_coeff_bank #(
    .N(N), .COEFF_WIDTH(COEFF_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .Q(Q)
  ) u_active (
    .clk      (clk),
    .rst      (rst),
    .load_en  (swap),
    .load_dat (shadow_coeffs),
    .wr_en    (1'b0),
    .wr_addr  ('0),
    .wr_dat   ('0),
    .coeffs   (packed_coeffs)
  );

  assign wr_ready = wr_ready_q;
  assign busy     = busy_q;
  assign settled  = settled_q;
  assign addr_err = addr_err_q;

endmodule

// File: tb/tb_fir_coeff_sequencer.sv
module tb_fir_coeff_sequencer;

  localparam int N  = 4;
  localparam int CW = 16;
  localparam int AW = 3;
  localparam int PW = CW * (N + 1);

  logic          clk;
  logic          rst;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [CW-1:0] wr_data;
  logic          commit;
  logic          sample_en;
  logic [PW-1:0] packed_coeffs;
  logic          busy;
  logic          settled;
  logic          addr_err;

  fir_coeff_sequencer #(.N(N), .COEFF_WIDTH(CW), .ADDR_WIDTH(AW), .Q(14)) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .commit        (commit),
    .sample_en     (sample_en),
    .packed_coeffs (packed_coeffs),
    .busy          (busy),
    .settled       (settled),
    .addr_err      (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: two coefficient arrays, a "swap outstanding" flag and the
  // number of strobes seen since the last swap (saturating at N+1).
  logic [CW-1:0] m_shadow [0:N];
  logic [CW-1:0] m_active [0:N];
  bit            m_pending;
  int            m_since;
  bit            m_err;

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [PW-1:0] m_pack();
    logic [PW-1:0] p;
    for (int t = 0; t <= N; t++) p[t*CW +: CW] = m_active[t];
    return p;
  endfunction

  task automatic model_step();
    bit acc;
    if (rst) begin
      for (int t = 0; t <= N; t++) begin
        m_shadow[t] = '0;
        m_active[t] = '0;
      end
      m_shadow[0] = 16'h4000;
      m_active[0] = 16'h4000;
      m_pending = 0;
      m_since   = N + 1;
      m_err     = 0;
      return;
    end
    acc   = wr_valid && !m_pending;
    m_err = acc && (int'(wr_addr) > N);
    if (acc && int'(wr_addr) <= N) m_shadow[int'(wr_addr)] = wr_data;
    if (m_pending) begin
      if (sample_en) begin
        for (int t = 0; t <= N; t++) m_active[t] = m_shadow[t];
        m_pending = 0;
        m_since   = 0;
      end
    end else if (commit) begin
      m_pending = 1;
    end else if (sample_en && m_since < N + 1) begin
      m_since++;
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [AW-1:0] a,
                       input logic [CW-1:0] d, input logic c, input logic s);
    rst = r; wr_valid = v; wr_addr = a; wr_data = d; commit = c; sample_en = s;
  endtask

  // One clock: advance the model on the applied inputs, then compare after the edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("model_coeffs",   packed_coeffs, m_pack());
    chk("model_busy",     PW'(busy),     PW'(m_pending));
    chk("model_settled",  PW'(settled),  PW'(!m_pending && m_since >= N + 1));
    chk("model_wr_ready", PW'(wr_ready), PW'(!m_pending));
    chk("model_addr_err", PW'(addr_err), PW'(m_err));
  endtask

  typedef struct {
    logic          r, v;
    logic [AW-1:0] a;
    logic [CW-1:0] d;
    logic          c, s;
    logic          e_busy, e_settled, e_ready, e_err;
    logic [PW-1:0] e_coeffs;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic v, input logic [AW-1:0] a,
                              input logic [CW-1:0] d, input logic c, input logic s,
                              input logic eb, input logic es, input logic er,
                              input logic ee, input logic [PW-1:0] ec);
    vec_t x;
    x.r = r; x.v = v; x.a = a; x.d = d; x.c = c; x.s = s;
    x.e_busy = eb; x.e_settled = es; x.e_ready = er; x.e_err = ee; x.e_coeffs = ec;
    return x;
  endfunction

  logic [PW-1:0] ID, SA, SB, SC;
  vec_t vt [27];

  initial begin
    ID = {16'd0, 16'd0, 16'd0, 16'd0, 16'h4000};
    SA = {16'd5000, 16'd4000, 16'd3000, 16'd2000, 16'd1000};
    SB = {16'd5000, 16'd4000, 16'd3000, 16'd2000, 16'd7};
    SC = {16'd5000, 16'd4000, 16'd3000, 16'hFFFB, 16'd7};

    //            r  v  a  d          c  s  busy set rdy err coeffs
    vt[0]  = mk(1, 0, 0, 0,          0, 0, 0, 1, 1, 0, ID);
    for (int i = 0; i <= N; i++)
      vt[1+i] = mk(0, 1, AW'(i), CW'(1000*(i+1)), 0, 0, 0, 1, 1, 0, ID);
    vt[6]  = mk(0, 0, 0, 0,          1, 0, 1, 0, 0, 0, ID);   // commit
    vt[7]  = mk(0, 0, 0, 0,          0, 0, 1, 0, 0, 0, ID);
    vt[8]  = mk(0, 0, 0, 0,          0, 0, 1, 0, 0, 0, ID);
    vt[9]  = mk(0, 0, 0, 0,          0, 1, 0, 0, 1, 0, SA);   // swap edge
    for (int i = 10; i <= 13; i++)
      vt[i] = mk(0, 0, 0, 0,         0, 1, 0, 0, 1, 0, SA);
    vt[14] = mk(0, 0, 0, 0,          0, 1, 0, 1, 1, 0, SA);   // 5th strobe
    vt[15] = mk(0, 1, 0, 16'd7,      0, 0, 0, 1, 1, 0, SA);
    vt[16] = mk(0, 0, 0, 0,          1, 1, 1, 0, 0, 0, SA);   // commit+strobe: no swap
    vt[17] = mk(0, 0, 0, 0,          0, 1, 0, 0, 1, 0, SB);
    vt[18] = mk(0, 1, 3'd6, 16'd999, 0, 0, 0, 0, 1, 1, SB);   // bad address
    vt[19] = mk(0, 0, 0, 0,          0, 0, 0, 0, 1, 0, SB);
    vt[20] = mk(0, 0, 0, 0,          1, 0, 1, 0, 0, 0, SB);
    vt[21] = mk(0, 1, 1, 16'hFFFB,   0, 0, 1, 0, 0, 0, SB);   // held write, blocked
    vt[22] = mk(0, 1, 1, 16'hFFFB,   0, 0, 1, 0, 0, 0, SB);
    vt[23] = mk(0, 1, 1, 16'hFFFB,   0, 1, 0, 0, 1, 0, SB);   // swap, write still blocked
    vt[24] = mk(0, 1, 1, 16'hFFFB,   0, 0, 0, 0, 1, 0, SB);   // write accepted
    vt[25] = mk(0, 0, 0, 0,          1, 0, 1, 0, 0, 0, SB);
    vt[26] = mk(0, 0, 0, 0,          0, 1, 0, 0, 1, 0, SC);

    drive(1, 0, 0, 0, 0, 0);
    tick();
    tick();

    for (int i = 0; i < 27; i++) begin
      drive(vt[i].r, vt[i].v, vt[i].a, vt[i].d, vt[i].c, vt[i].s);
      tick();
      chk($sformatf("vec%0d_coeffs", i),  packed_coeffs, vt[i].e_coeffs);
      chk($sformatf("vec%0d_busy", i),    PW'(busy),     PW'(vt[i].e_busy));
      chk($sformatf("vec%0d_settled", i), PW'(settled),  PW'(vt[i].e_settled));
      chk($sformatf("vec%0d_ready", i),   PW'(wr_ready), PW'(vt[i].e_ready));
      chk($sformatf("vec%0d_err", i),     PW'(addr_err), PW'(vt[i].e_err));
    end

    // Commit during SETTLE after two strobes: count restarts from the new swap.
    drive(0, 0, 0, 0, 0, 1); tick(); tick();
    drive(0, 0, 0, 0, 1, 0); tick();
    chk("restart_busy", PW'(busy), PW'(1));
    drive(0, 0, 0, 0, 0, 1); tick();
    chk("restart_swap_busy", PW'(busy), PW'(0));
    for (int k = 1; k <= N + 1; k++) begin
      tick();
      chk($sformatf("restart_settled_%0d", k), PW'(settled), PW'(k == N + 1));
    end

    // Reset while PENDING discards the commit and the shadow contents.
    drive(0, 1, 2, 16'hFFF9, 0, 0); tick();
    drive(0, 0, 0, 0, 1, 0); tick();
    chk("pre_rst_busy", PW'(busy), PW'(1));
    drive(1, 0, 0, 0, 0, 0); tick();
    chk("rst_coeffs",  packed_coeffs, ID);
    chk("rst_busy",    PW'(busy),     PW'(0));
    chk("rst_settled", PW'(settled),  PW'(1));
    drive(0, 0, 0, 0, 1, 0); tick();
    drive(0, 0, 0, 0, 0, 1); tick();
    chk("post_rst_swap_identity", packed_coeffs, ID);

    // Randomized traffic against the model.
    for (int k = 0; k < 800; k++) begin
      drive(($urandom_range(0, 99) == 0),
            ($urandom_range(0, 1) == 1),
            AW'($urandom_range(0, 7)),
            CW'($urandom),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 2) == 0));
      tick();
    end

    drive(0, 0, 0, 0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
